// File: rtl/pio_pattern_scheduler.sv
// Avalon-MM master that replays a CSR-loaded bit pattern onto a PIO data register, one bit per PERIOD clocks.
// Optional wrap interrupt output (irq, IE in CTRL bit 2) is built only when PIO_SCHED_IRQ_EN is defined.
module pio_pattern_scheduler #(
  parameter int         PAT_LEN  = 32,
  parameter int         CNT_W    = 32,
  parameter logic [1:0] PIO_ADDR = 2'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
`ifdef PIO_SCHED_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int IDX_W = 5;

  typedef enum logic [1:0] {IDLE, WRITE, COUNT} state_t;

  state_t             state_q, state_d;
  logic               en_q, en_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [31:0]        pattern_q, pattern_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               wrap_q, wrap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wbit_q, wbit_d;
  logic               ie_rd;

  logic csr_wr, ctrl_wr, period_wr, pattern_wr, status_wr, restart, accept;

  assign csr_wr     = s_chipselect && !s_write_n;
  assign ctrl_wr    = csr_wr && (s_address == 2'd0);
  assign period_wr  = csr_wr && (s_address == 2'd1);
  assign pattern_wr = csr_wr && (s_address == 2'd2);
  assign status_wr  = csr_wr && (s_address == 2'd3);
  assign restart    = ctrl_wr && s_writedata[1];
  assign accept     = (state_q == WRITE) && !m_waitrequest;

`ifdef PIO_SCHED_IRQ_EN
  logic ie_q, ie_d, irq_q;

  always_comb begin
    ie_d = ie_q;
    if (ctrl_wr) ie_d = s_writedata[2];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= wrap_d & ie_d;
    end
  end

  assign ie_rd = ie_q;
  assign irq   = irq_q;
`else
  assign ie_rd = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    period_d  = period_q;
    pattern_d = pattern_q;
    idx_d     = idx_q;
    wrap_d    = wrap_q;
    cnt_d     = cnt_q;
    wbit_d    = wbit_q;

    if (ctrl_wr)    en_d      = s_writedata[0];
    if (period_wr)  period_d  = (s_writedata < 32'd2) ? CNT_W'(2) : s_writedata[CNT_W-1:0];
    if (pattern_wr) pattern_d = s_writedata;
    if (status_wr && s_writedata[1]) wrap_d = 1'b0;
    if (restart)    idx_d     = '0;

    case (state_q)
      IDLE: begin
        if (en_d) begin
          state_d = WRITE;
          wbit_d  = pattern_d[idx_d];
        end
      end
      WRITE: begin
        if (accept) begin
          if (!restart) idx_d = (idx_q == IDX_W'(PAT_LEN - 1)) ? '0 : idx_q + 1'b1;
          if (idx_q == IDX_W'(PAT_LEN - 1)) wrap_d = 1'b1;
          // COUNT spans PERIOD-1 cycles so accepts land exactly PERIOD apart
          cnt_d   = period_q - CNT_W'(2);
          state_d = en_d ? COUNT : IDLE;
        end
      end
      COUNT: begin
        if (!en_d) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = WRITE;
          wbit_d  = pattern_d[idx_d];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      period_q  <= CNT_W'(2);
      pattern_q <= '0;
      idx_q     <= '0;
      wrap_q    <= 1'b0;
      cnt_q     <= '0;
      wbit_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      period_q  <= period_d;
      pattern_q <= pattern_d;
      idx_q     <= idx_d;
      wrap_q    <= wrap_d;
      cnt_q     <= cnt_d;
      wbit_q    <= wbit_d;
    end
  end

  assign m_address    = PIO_ADDR;
  assign m_chipselect = (state_q == WRITE);
  assign m_write_n    = (state_q != WRITE);
  assign m_writedata  = {31'b0, wbit_q & (state_q == WRITE)};

  always_comb begin
    s_readdata = '0;
    case (s_address)
      2'd0:    s_readdata = {29'b0, ie_rd, 1'b0, en_q};
      2'd1:    s_readdata = 32'(period_q);
      2'd2:    s_readdata = pattern_q;
      default: s_readdata = {19'b0, idx_q, 6'b0, wrap_q, (state_q != IDLE)};
    endcase
  end

endmodule

// File: tb/tb_pio_pattern_scheduler.sv
// Directed + randomized bench for pio_pattern_scheduler (PAT_LEN=4); reference model tracks
// expected bit sequence, write spacing, index and WRAP from the CSR-level rules.
module tb_pio_pattern_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  s_address;
  logic        s_chipselect;
  logic        s_write_n;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
`ifdef PIO_SCHED_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  pio_pattern_scheduler #(.PAT_LEN(4), .CNT_W(32), .PIO_ADDR(2'd0)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
    .s_writedata(s_writedata), .s_readdata(s_readdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest)
`ifdef PIO_SCHED_IRQ_EN
    , .irq(irq)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  // reference model state
  int          exp_idx = 0;
  logic [31:0] exp_pat = '0;
  int          exp_per = 2;
  int          reload_per = 2;
  bit          exp_en = 0, exp_ie = 0, exp_wrap = 0, wrap_set_now = 0;
  bit          have_prev = 0;
  int          last_acc = 0;
  int          stall_cnt = 0;
  bit          prev_stall = 0;
  logic [31:0] st_dat;
  bit          wait_rand = 0;
  logic [31:0] rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe the master port just before the edge, update the model, advance.
  task automatic tick();
    logic wr_now;
    if (wait_rand) m_waitrequest = ($urandom_range(0, 2) == 0);
    wr_now = m_chipselect && !m_write_n;
    wrap_set_now = 0;
    if (prev_stall) begin
      check("stall_strobe", {30'b0, m_chipselect, m_write_n}, 32'h2);
      check("stall_data", m_writedata, st_dat);
    end
    prev_stall = 0;
    if (wr_now && m_waitrequest) begin
      stall_cnt++;
      prev_stall = 1;
      st_dat = m_writedata;
    end else if (wr_now) begin
      check("wr_bit", m_writedata, {31'b0, exp_pat[exp_idx]});
      check("wr_addr", {30'b0, m_address}, 32'h0);
      if (have_prev) check("wr_gap", 32'(cyc - last_acc), 32'(reload_per + stall_cnt));
      last_acc   = cyc;
      reload_per = exp_per;
      have_prev  = 1;
      stall_cnt  = 0;
      if (exp_idx == 3) begin
        exp_wrap = 1;
        wrap_set_now = 1;
      end
      exp_idx = (exp_idx + 1) % 4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    s_address = a; s_chipselect = 1'b1; s_write_n = 1'b0; s_writedata = d;
    tick();
    s_chipselect = 1'b0; s_write_n = 1'b1;
    case (a)
      2'd0: begin
        if (d[0] && !exp_en) begin
          have_prev = 0;
          stall_cnt = 0;
        end
        exp_en = d[0];
        if (d[1]) exp_idx = 0;
`ifdef PIO_SCHED_IRQ_EN
        exp_ie = d[2];
`endif
      end
      2'd1: exp_per = (d < 2) ? 2 : int'(d);
      2'd2: exp_pat = d;
      default: if (d[1]) exp_wrap = wrap_set_now;
    endcase
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    s_address = a; s_chipselect = 1'b1; s_write_n = 1'b1;
    #1;
    d = s_readdata;
    s_chipselect = 1'b0;
  endtask

  task automatic check_status(input string tag);
    csr_rd(2'd3, rd);
    check(tag, rd & 32'h1F02, (32'(exp_idx) << 8) | (32'(exp_wrap) << 1));
`ifdef PIO_SCHED_IRQ_EN
    check({tag, "_irq"}, {31'b0, irq}, {31'b0, exp_wrap & exp_ie});
`endif
  endtask

  initial begin
    reset_n = 1'b0; s_address = '0; s_chipselect = 1'b0; s_write_n = 1'b1;
    s_writedata = '0; m_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", {31'b0, m_chipselect}, 32'h0);
    check("rst_wn", {31'b0, m_write_n}, 32'h1);
    check("rst_wdat", m_writedata, 32'h0);
`ifdef PIO_SCHED_IRQ_EN
    check("rst_irq", {31'b0, irq}, 32'h0);
`endif
    reset_n = 1'b1;
    csr_rd(2'd0, rd); check("rst_ctrl", rd, 32'h0);
    csr_rd(2'd1, rd); check("rst_period", rd, 32'h2);
    csr_rd(2'd2, rd); check("rst_pattern", rd, 32'h0);
    csr_rd(2'd3, rd); check("rst_status", rd, 32'h0);

    // PERIOD=4, PATTERN=0xA: expect 0,1,0,1 spaced 4 clocks, repeating
    csr_wr(2'd1, 32'd4);
    csr_wr(2'd2, 32'hA);
    csr_wr(2'd0, 32'h1);
    check("en_first_cycle_cs", {31'b0, m_chipselect}, 32'h1);
    csr_rd(2'd3, rd); check("en_busy", rd & 32'h1, 32'h1);
    repeat (20) tick();
    check_status("run_status");

    // stall of 3 cycles on a write
    for (int i = 0; i < 20 && !m_chipselect; i++) tick();
    check("stall_found", {31'b0, m_chipselect}, 32'h1);
    m_waitrequest = 1'b1;
    repeat (3) tick();
    m_waitrequest = 1'b0;
    repeat (10) tick();

    // PERIOD=0 stored as 2
    csr_wr(2'd1, 32'd0);
    csr_rd(2'd1, rd); check("period_min", rd, 32'h2);
    repeat (12) tick();

    // clear EN in COUNT at idx 2, then resume
    for (int i = 0; i < 40 && !(exp_idx == 2 && !m_chipselect); i++) tick();
    check("count_idx2_found", {31'b0, (exp_idx == 2 && !m_chipselect)}, 32'h1);
    csr_wr(2'd0, 32'h0);
    check("dis_cs", {31'b0, m_chipselect}, 32'h0);
    csr_rd(2'd3, rd); check("dis_status", rd & 32'h1F01, 32'h200);
    repeat (3) tick();
    check("dis_hold_cs", {31'b0, m_chipselect}, 32'h0);
    csr_wr(2'd2, 32'h4);
    csr_wr(2'd0, 32'h1);
    check("resume_bit", m_writedata, 32'h1);
    repeat (6) tick();

    // restart at idx 0
    csr_wr(2'd0, 32'h0);
    repeat (3) tick();
    csr_wr(2'd0, 32'h3);
    check_status("restart_status");
    repeat (10) tick();

    // WRAP / irq: clear away from a wrap, then clear coincident with a wrap
    csr_wr(2'd0, 32'h5);
    csr_rd(2'd0, rd); check("ctrl_rd", rd, {29'b0, exp_ie, 1'b0, exp_en});
    repeat (2) tick();
    csr_wr(2'd3, 32'h2);
    check_status("wrap_clear");
    for (int i = 0; i < 40 && !(m_chipselect && exp_idx == 3); i++) tick();
    check("wrap_write_found", {31'b0, (m_chipselect && exp_idx == 3)}, 32'h1);
    csr_wr(2'd3, 32'h2);
    check("wrap_set_wins", {31'b0, exp_wrap}, 32'h1);
    check_status("wrap_coincident");

    // randomized runs with random waitrequest
    for (int r = 0; r < 8; r++) begin
      csr_wr(2'd0, 32'h0);
      for (int i = 0; i < 40 && m_chipselect; i++) tick();
      tick();
      csr_rd(2'd3, rd); check("rnd_idle", rd & 32'h1, 32'h0);
      csr_wr(2'd2, $urandom);
      csr_wr(2'd1, 32'($urandom_range(0, 7)));
      csr_wr(2'd0, {29'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1});
      wait_rand = 1;
      repeat ($urandom_range(20, 60)) tick();
      check_status("rnd_status");
      if ($urandom_range(0, 1) == 1) begin
        csr_wr(2'd3, 32'h2);
        check_status("rnd_clear");
      end
      wait_rand = 0;
      m_waitrequest = 1'b0;
    end

    // reset while a write is stalled
    for (int i = 0; i < 40 && !m_chipselect; i++) tick();
    check("rstmid_found", {31'b0, m_chipselect}, 32'h1);
    m_waitrequest = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    check("rstmid_cs", {31'b0, m_chipselect}, 32'h0);
    check("rstmid_wn", {31'b0, m_write_n}, 32'h1);
    check("rstmid_wdat", m_writedata, 32'h0);
    csr_rd(2'd0, rd); check("rstmid_ctrl", rd, 32'h0);
    csr_rd(2'd1, rd); check("rstmid_period", rd, 32'h2);
    csr_rd(2'd2, rd); check("rstmid_pattern", rd, 32'h0);
    csr_rd(2'd3, rd); check("rstmid_status", rd, 32'h0);
    reset_n = 1'b1;
    m_waitrequest = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
